event_timer: RTL and testbench

- Programmable prescaled interval timer; first functional stage inside top_level, driven directly by the bench-level clk/reset.
- Generates periodic or one-shot compare matches, a sticky interrupt with acknowledge, and a run-status output.
- Downstream logic consumes tick/match_pulse/irq as its timebase and event source.

---
 rtl/event_timer.sv | 121 ++++++++++++
 tb/tb_event_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/event_timer.sv
// Prescaled interval timer: periodic/one-shot compare match, sticky irq, run status.
// Optional capture unit built when EVENT_TIMER_CAPTURE_EN is defined.
module event_timer #(
    parameter int PW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          mode_periodic,
    input  logic [PW-1:0] prescale,
    input  logic [CW-1:0] compare,
    input  logic          irq_ack,
    input  logic          capture_in,
    output logic          running,
    output logic [CW-1:0] count,
    output logic          tick,
    output logic          match_pulse,
    output logic          irq,
    output logic [CW-1:0] cap_value,
    output logic          cap_valid
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_d;
    logic [PW-1:0] pre_cnt;
    logic [PW-1:0] p_q;
    logic [CW-1:0] c_q;
    logic          m_q;
    logic          stop_run;
    logic          start_go;

    // stop only acts in RUN, but it still masks a same-cycle start everywhere
    assign stop_run = stop & (state == RUN);
    assign start_go = start & ~stop;

    assign tick        = running & (pre_cnt == p_q);
    assign match_pulse = tick & (count == c_q);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (stop_run)
            state_d = IDLE;
        else if (start_go)
            state_d = RUN;
        else if (match_pulse && !m_q)
            state_d = DONE;
    end

    always_comb begin
        running = (state == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            count   <= '0;
            p_q     <= '0;
            c_q     <= '0;
            m_q     <= 1'b0;
        end else if (stop_run) begin
            pre_cnt <= pre_cnt;
            count   <= count;
        end else if (start_go) begin
            p_q     <= prescale;
            c_q     <= compare;
            m_q     <= mode_periodic;
            pre_cnt <= '0;
            count   <= '0;
        end else if (state == RUN) begin
            if (tick) begin
                pre_cnt <= '0;
                if (match_pulse)
                    count <= m_q ? '0 : c_q;
                else
                    count <= count + CW'(1);
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)            irq <= 1'b0;
        else if (match_pulse) irq <= 1'b1;
        else if (irq_ack)     irq <= 1'b0;
    end

`ifdef EVENT_TIMER_CAPTURE_EN
    logic cap_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_prev  <= 1'b0;
            cap_value <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_prev <= capture_in;
            if (capture_in && !cap_prev && running) begin
                cap_value <= count;
                cap_valid <= 1'b1;
            end else if (irq_ack) begin
                cap_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture_in;
    assign cap_value      = '0;
    assign cap_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_event_timer.sv
// Scoreboarded bench for event_timer: expected match cycles are queued at start,
// a negedge monitor pops them as match_pulse appears; other checks are direct.
module tb_event_timer;

    localparam int PW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode_periodic = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [CW-1:0] compare = '0;
    logic          irq_ack = 1'b0;
    logic          capture_in = 1'b0;
    logic          running;
    logic [CW-1:0] count;
    logic          tick;
    logic          match_pulse;
    logic          irq;
    logic [CW-1:0] cap_value;
    logic          cap_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base;
    int exp_match_q[$];

    event_timer #(.PW(PW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .mode_periodic(mode_periodic), .prescale(prescale), .compare(compare),
        .irq_ack(irq_ack), .capture_in(capture_in), .running(running),
        .count(count), .tick(tick), .match_pulse(match_pulse), .irq(irq),
        .cap_value(cap_value), .cap_valid(cap_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every match_pulse must correspond to the next queued cycle.
    always @(negedge clk) begin
        if (!reset && match_pulse) begin
            if (exp_match_q.size() == 0)
                check("match_spurious", 32'(cyc), 32'hFFFF_FFFF);
            else
                check("match_cycle", 32'(cyc), 32'(exp_match_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int target);
        int guard = 0;
        while (cyc < target && guard < 1000) begin
            step();
            guard++;
        end
        if (cyc != target) check("wait_cycle", 32'(cyc), 32'(target));
    endtask

    task automatic start_timer(input int p, input int c, input logic m, output int b);
        prescale      = PW'(p);
        compare       = CW'(c);
        mode_periodic = m;
        start         = 1'b1;
        step();
        start = 1'b0;
        b = cyc;
    endtask

    task automatic push_matches(input int b, input int p, input int c, input int n);
        for (int k = 1; k <= n; k++)
            exp_match_q.push_back(b + k * (p + 1) * (c + 1) - 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        check("rst_running", 32'(running), 0);
        check("rst_count", 32'(count), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_cap_value", 32'(cap_value), 0);
        check("rst_cap_valid", 32'(cap_valid), 0);
        reset = 1'b0;
        step();

        // P=1, C=3 periodic
        start_timer(1, 3, 1'b1, base);
        push_matches(base, 1, 3, 3);
        for (int k = 0; k < 8; k++) begin
            check("t1_tick", 32'(tick), 32'(k % 2 == 1));
            check("t1_count", 32'(count), 32'(k / 2));
            step();
        end
        check("t1_count_wrap", 32'(count), 0);
        check("t1_irq_set", 32'(irq), 1);
        wait_cycle(base + 9);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t1_irq_ack", 32'(irq), 0);
        wait_cycle(base + 24);
        check("t1_irq_reset", 32'(irq), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t1_stopped", 32'(running), 0);

        // P=0, C=4 one-shot
        start_timer(0, 4, 1'b0, base);
        push_matches(base, 0, 4, 1);
        wait_cycle(base + 5);
        check("t2_done_running", 32'(running), 0);
        check("t2_done_count", 32'(count), 4);
        for (int k = 0; k < 5; k++) begin
            check("t2_no_tick", 32'(tick), 0);
            step();
        end
        check("t2_hold_count", 32'(count), 4);
        start_timer(0, 4, 1'b0, base);
        push_matches(base, 0, 4, 1);
        check("t2_restart_count", 32'(count), 0);
        check("t2_restart_running", 32'(running), 1);
        wait_cycle(base + 6);

        // P=2, C=10 periodic, stop at count 5
        start_timer(2, 10, 1'b1, base);
        wait_cycle(base + 15);
        check("t3_count5", 32'(count), 5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t3_stop_running", 32'(running), 0);
        repeat (3) step();
        check("t3_stop_hold", 32'(count), 5);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("t3_startstop_idle", 32'(running), 0);
        check("t3_startstop_count", 32'(count), 5);

        // ack coincident with match; compare change mid-run ignored
        start_timer(0, 3, 1'b1, base);
        push_matches(base, 0, 3, 3);
        irq_ack = 1'b1;
        compare = CW'(2);
        step();
        irq_ack = 1'b0;
        check("t4_irq_cleared", 32'(irq), 0);
        wait_cycle(base + 3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("t4_set_wins", 32'(irq), 1);
        wait_cycle(base + 12);
        stop = 1'b1;
        step();
        stop = 1'b0;

        // reset mid-run
        start_timer(0, 20, 1'b1, base);
        wait_cycle(base + 7);
        check("t5_pre_count", 32'(count), 7);
        check("t5_pre_irq", 32'(irq), 1);
        reset = 1'b1;
        step();
        check("t5_running", 32'(running), 0);
        check("t5_count", 32'(count), 0);
        check("t5_tick", 32'(tick), 0);
        check("t5_irq", 32'(irq), 0);
        check("t5_cap_valid", 32'(cap_valid), 0);
        reset = 1'b0;
        step();
        check("t5_idle_after", 32'(running), 0);

        // capture
        start_timer(0, 100, 1'b1, base);
        wait_cycle(base + 37);
        capture_in = 1'b1;
        step();
`ifdef EVENT_TIMER_CAPTURE_EN
        check("t6_cap_value", 32'(cap_value), 37);
        check("t6_cap_valid", 32'(cap_valid), 1);
`else
        check("t6_cap_value_off", 32'(cap_value), 0);
        check("t6_cap_valid_off", 32'(cap_valid), 0);
`endif
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        capture_in = 1'b0;
        check("t6_ack_valid", 32'(cap_valid), 0);
`ifdef EVENT_TIMER_CAPTURE_EN
        check("t6_value_kept", 32'(cap_value), 37);
`else
        check("t6_value_off", 32'(cap_value), 0);
`endif
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();

        check("sb_empty", 32'(exp_match_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
